// File: rtl/pattern_scan_pkg.sv
// Shared state encoding for the pattern scan controller.
package pattern_scan_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/pattern_window.sv
// Serial window: shift register, fill counter and pattern comparator.
// The match output is evaluated on the post-shift window, so it is
// valid in the same cycle as the accepted bit.
module pattern_window #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift,
   input  logic             din,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             match
);
   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  window, window_next;
   logic [FILL_W-1:0] fill, fill_next;

   // Next window/fill and match for the bit being offered this cycle
   always_comb begin
      window_next = {window[PAT_W-2:0], din};
      fill_next   = (fill == FILL_MAX) ? fill : fill + 1'b1;
      match       = shift && (fill_next == FILL_MAX) && (window_next == pattern);
   end

   // Window state; non-overlap mode restarts the fill after a hit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         window <= '0;
         fill   <= '0;
      end else if (clr) begin
         window <= '0;
         fill   <= '0;
      end else if (shift) begin
         window <= window_next;
         fill   <= (match && !overlap) ? '0 : fill_next;
      end
   end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// Start/done sequencer around pattern_window: latches config, pulls bits
// from a valid/ready source, counts matches up to a target.
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic             ip_valid,
   input  logic             ip,
   output logic             ip_ready,
   output logic             busy,
   output logic             seq_det,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt
);
   logic [1:0]       state;
   logic [PAT_W-1:0] pattern_q;
   logic             overlap_q;
   logic [CNT_W-1:0] target_q;
   logic             accept, match;
   logic [CNT_W-1:0] cnt_inc;

   // Handshake and status decoded straight from state; abort blocks the accept
   always_comb begin
      ip_ready = (state == ST_RUN);
      busy     = (state == ST_ARM) || (state == ST_RUN);
      accept   = ip_ready && ip_valid && !abort;
      cnt_inc  = match_cnt + 1'b1;
   end

   pattern_window #(.PAT_W(PAT_W)) u_window (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == ST_ARM),
      .shift   (accept),
      .din     (ip),
      .pattern (pattern_q),
      .overlap (overlap_q),
      .match   (match)
   );

   // Controller FSM, config latch and match counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         pattern_q <= '0;
         overlap_q <= 1'b0;
         target_q  <= '0;
         match_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               pattern_q <= cfg_pattern;
               overlap_q <= cfg_overlap;
               target_q  <= cfg_target;
               state     <= ST_ARM;
            end
            ST_ARM: begin
               match_cnt <= '0;
               state     <= (target_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (match) begin
                  match_cnt <= cnt_inc;
                  if (cnt_inc == target_q) state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Registered pulses: seq_det follows the accepted bit, done follows DONE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seq_det <= 1'b0;
         done    <= 1'b0;
      end else begin
         seq_det <= match;
         done    <= (state == ST_DONE);
      end
   end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with hand-computed expectations.
module tb_pattern_scan_ctrl;
   localparam int PAT_W = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [PAT_W-1:0] cfg_pattern = '0;
   logic             cfg_overlap = 1'b0;
   logic [CNT_W-1:0] cfg_target = '0;
   logic             ip_valid = 1'b0;
   logic             ip = 1'b0;
   logic             ip_ready, busy, seq_det, done;
   logic [CNT_W-1:0] match_cnt;

   int tests = 0;
   int fails = 0;

   pattern_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
      .ip_valid(ip_valid), .ip(ip), .ip_ready(ip_ready), .busy(busy),
      .seq_det(seq_det), .done(done), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start pulse; on return the DUT is in ARM
   task automatic start_run(input logic [PAT_W-1:0] pat, input logic ovl, input logic [CNT_W-1:0] tgt);
      cfg_pattern = pat;
      cfg_overlap = ovl;
      cfg_target  = tgt;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input logic b);
      ip_valid = 1'b1;
      ip = b;
      tick();
      ip_valid = 1'b0;
   endtask

   logic [6:0] stream;

   initial begin
      stream = 7'b1001001;

      // Reset state
      repeat (2) tick();
      chk("rst_ip_ready", 32'(ip_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_seq_det", 32'(seq_det), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_match_cnt", 32'(match_cnt), 0);
      rst = 1'b1;
      tick();

      // 1: overlap, target 3, hits after bits 4 and 7
      start_run(4'b1001, 1'b1, 8'd3);
      chk("t1_arm_busy", 32'(busy), 1);
      chk("t1_arm_ready", 32'(ip_ready), 0);
      tick();
      chk("t1_run_ready", 32'(ip_ready), 1);
      for (int i = 0; i < 7; i++) begin
         feed(stream[6-i]);
         chk($sformatf("t1_det_bit%0d", i + 1), 32'(seq_det), (i == 3 || i == 6) ? 1 : 0);
      end
      chk("t1_cnt", 32'(match_cnt), 2);
      chk("t1_busy", 32'(busy), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t1_abort_busy", 32'(busy), 0);
      chk("t1_abort_cnt", 32'(match_cnt), 2);
      tick();
      chk("t1_abort_nodone", 32'(done), 0);

      // 2: no overlap, single hit after bit 4
      start_run(4'b1001, 1'b0, 8'd3);
      tick();
      for (int i = 0; i < 7; i++) begin
         feed(stream[6-i]);
         chk($sformatf("t2_det_bit%0d", i + 1), 32'(seq_det), (i == 3) ? 1 : 0);
      end
      chk("t2_cnt", 32'(match_cnt), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();

      // 3: target 2 reached on bit 7, done one cycle after seq_det
      start_run(4'b1001, 1'b1, 8'd2);
      tick();
      for (int i = 0; i < 7; i++) feed(stream[6-i]);
      chk("t3_det", 32'(seq_det), 1);
      chk("t3_ready_off", 32'(ip_ready), 0);
      chk("t3_busy_off", 32'(busy), 0);
      chk("t3_done_early", 32'(done), 0);
      ip_valid = 1'b1;
      ip = 1'b1;
      tick();
      chk("t3_done", 32'(done), 1);
      chk("t3_det_clr", 32'(seq_det), 0);
      chk("t3_ready_after", 32'(ip_ready), 0);
      chk("t3_cnt", 32'(match_cnt), 2);
      tick();
      ip_valid = 1'b0;
      chk("t3_done_pulse", 32'(done), 0);
      chk("t3_cnt_held", 32'(match_cnt), 2);

      // 4: target 0 -> ARM, DONE, done on 3rd cycle, no bit accepted
      ip_valid = 1'b1;
      start_run(4'b1001, 1'b1, 8'd0);
      chk("t4_arm_busy", 32'(busy), 1);
      tick();
      chk("t4_done_state_busy", 32'(busy), 0);
      chk("t4_done_state_ready", 32'(ip_ready), 0);
      chk("t4_done_early", 32'(done), 0);
      tick();
      chk("t4_done", 32'(done), 1);
      chk("t4_cnt", 32'(match_cnt), 0);
      tick();
      chk("t4_done_pulse", 32'(done), 0);
      ip_valid = 1'b0;

      // 5: valid gaps keep the pattern; abort beats a completing bit
      start_run(4'b1001, 1'b1, 8'd3);
      tick();
      feed(1'b1);
      ip = 1'b1;
      tick();
      tick();
      feed(1'b0);
      tick();
      feed(1'b0);
      chk("t5_det_early", 32'(seq_det), 0);
      feed(1'b1);
      chk("t5_det", 32'(seq_det), 1);
      chk("t5_cnt", 32'(match_cnt), 1);
      feed(1'b0);
      feed(1'b0);
      abort = 1'b1;
      ip_valid = 1'b1;
      ip = 1'b1;
      tick();
      abort = 1'b0;
      ip_valid = 1'b0;
      chk("t5_abort_det", 32'(seq_det), 0);
      chk("t5_abort_cnt", 32'(match_cnt), 1);
      chk("t5_abort_busy", 32'(busy), 0);
      tick();
      chk("t5_abort_nodone", 32'(done), 0);

      // 6: async reset mid-run, then a lone 1 does not match
      start_run(4'b1001, 1'b1, 8'd3);
      tick();
      feed(1'b1);
      feed(1'b0);
      feed(1'b0);
      #1 rst = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_ready", 32'(ip_ready), 0);
      chk("t6_rst_det", 32'(seq_det), 0);
      chk("t6_rst_done", 32'(done), 0);
      rst = 1'b1;
      tick();
      start_run(4'b1001, 1'b1, 8'd3);
      tick();
      feed(1'b1);
      chk("t6_det", 32'(seq_det), 0);
      chk("t6_cnt", 32'(match_cnt), 0);
      chk("t6_busy", 32'(busy), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
